spi_cfg_ctrl: RTL and testbench

SPI-slave configuration controller for the onboarding top level. It receives 16-bit write/read frames on three pad inputs, oversampled in the `clk` domain, and holds the register bank that configures the PWM peripheral: output enables, PWM enables and duty cycle. It sits between the `ui_in` pins and the PWM datapath, and it is the only writer of that datapath's configuration.

---
 rtl/spi_cfg_pkg.sv | 11 +
 rtl/spi_sync_edge.sv | 25 ++
 rtl/spi_cfg_ctrl.sv | 123 ++++++++++++
 tb/tb_spi_cfg_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: register map, frame length and FSM states shared by the SPI config controller.
package spi_cfg_pkg;
  localparam int ADDR_EN_OUT_LO = 0;
  localparam int ADDR_EN_OUT_HI = 1;
  localparam int ADDR_EN_PWM_LO = 2;
  localparam int ADDR_EN_PWM_HI = 3;
  localparam int ADDR_DUTY = 4;
  localparam int NUM_REGS = ADDR_DUTY + 1;
  localparam int FRAME_BITS = 16;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop pad synchronizer with one-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  assign level = sync[STAGES-1];
  assign rise = level & ~prev;
  assign fall = ~level & prev;
endmodule

// File: rtl/spi_cfg_ctrl.sv
// spi_cfg_ctrl: SPI mode-0 slave holding the PWM configuration registers.
// Define SPI_READBACK_EN to serve read frames on cipo.
module spi_cfg_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic       cipo_oe,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       txn_done
);
  import spi_cfg_pkg::*;
  localparam logic [6:0] MAX_A = 7'(MAX_ADDR);
  localparam logic [4:0] FULL = 5'(FRAME_BITS);
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic [15:0] sh_q, sh_d;
  logic [7:0] regs [NUM_REGS];
  logic sclk_rise, sclk_fall, sclk_unused;
  logic copi_s, copi_rise_unused, copi_fall_unused;
  logic ncs_rise, ncs_fall, ncs_unused;
  logic frame_ok, wr_ok;
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (.clk(clk), .rst_n(rst_n), .d(sclk),
    .level(sclk_unused), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_copi (.clk(clk), .rst_n(rst_n), .d(copi),
    .level(copi_s), .rise(copi_rise_unused), .fall(copi_fall_unused));
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ncs (.clk(clk), .rst_n(rst_n), .d(ncs),
    .level(ncs_unused), .rise(ncs_rise), .fall(ncs_fall));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      sh_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      sh_q <= sh_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    sh_d = sh_q;
    case (state_q)
      IDLE:
        if (ncs_fall) begin
          state_d = SHIFT;
          cnt_d = '0;
          ovf_d = 1'b0;
          sh_d = '0;
        end
      SHIFT:
        if (ncs_rise) state_d = COMMIT;
        else if (ncs_fall) begin
          cnt_d = '0;
          ovf_d = 1'b0;
          sh_d = '0;
        end else if (sclk_rise) begin
          if (cnt_q == FULL) ovf_d = 1'b1;
          else begin
            cnt_d = cnt_q + 5'd1;
            sh_d = {sh_q[14:0], copi_s};
          end
        end
      default: state_d = IDLE;
    endcase
  end
  assign frame_ok = (cnt_q == FULL) && !ovf_q;
  assign wr_ok = (state_q == COMMIT) && frame_ok && sh_q[15] && (sh_q[14:8] <= MAX_A);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok && sh_q[14:8] < 7'(NUM_REGS)) begin
      regs[sh_q[10:8]] <= sh_q[7:0];
    end
  assign en_reg_out_7_0 = regs[ADDR_EN_OUT_LO];
  assign en_reg_out_15_8 = regs[ADDR_EN_OUT_HI];
  assign en_reg_pwm_7_0 = regs[ADDR_EN_PWM_LO];
  assign en_reg_pwm_15_8 = regs[ADDR_EN_PWM_HI];
  assign pwm_duty_cycle = regs[ADDR_DUTY];
`ifdef SPI_READBACK_EN
  logic rd_q, load, rd_ok;
  logic [7:0] out_q, rd_val;
  // Header byte completes on the edge taking the count from 7 to 8.
  assign load = (state_q == SHIFT) && (cnt_q == 5'd7) && (cnt_d == 5'd8);
  assign rd_val = (sh_d[6:0] <= MAX_A && sh_d[6:0] < 7'(NUM_REGS)) ? regs[sh_d[2:0]] : 8'h00;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_q <= 1'b0;
      out_q <= '0;
    end else if (load) begin
      rd_q <= ~sh_d[7];
      out_q <= sh_d[7] ? 8'h00 : rd_val;
    end else if (state_q != SHIFT || cnt_d == 5'd0) begin
      rd_q <= 1'b0;
      out_q <= '0;
    end else if (rd_q && sclk_fall && cnt_q >= 5'd9) begin
      out_q <= {out_q[6:0], 1'b0};
    end
  assign rd_ok = (state_q == COMMIT) && frame_ok && !sh_q[15];
  assign cipo = out_q[7];
  assign cipo_oe = (state_q == SHIFT) && rd_q;
  assign txn_done = wr_ok | rd_ok;
`else
  logic unused_sclk_fall;
  assign unused_sclk_fall = sclk_fall;
  assign cipo = 1'b0;
  assign cipo_oe = 1'b0;
  assign txn_done = wr_ok;
`endif
endmodule

// File: tb/tb_spi_cfg_ctrl.sv
// tb_spi_cfg_ctrl: table-driven plus randomized frames against a register-map model.
module tb_spi_cfg_ctrl;
  localparam int S = 2;
  localparam int H = 5;
`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
  logic cipo, cipo_oe, txn_done;
  logic [7:0] r0, r1, r2, r3, r4;
  logic [39:0] dut_regs;
  int total = 0, passed = 0;
  int done_cnt, done_at;
  logic [15:0] cap_c, cap_oe;
  logic [7:0] model [5];

  typedef struct {
    logic [15:0] frame;
    int nbits;
    bit done;
    logic [39:0] regs;
  } vec_t;
  vec_t tbl [12];

  spi_cfg_ctrl #(.SYNC_STAGES(S), .MAX_ADDR(4)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo), .cipo_oe(cipo_oe),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4), .txn_done(txn_done));

  always #5 clk = ~clk;
  assign dut_regs = {r4, r3, r2, r1, r0};

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [39:0] mvec();
    return {model[4], model[3], model[2], model[1], model[0]};
  endfunction

  task automatic send(input logic [15:0] f, input int n, input bit close);
    cap_c = '0;
    cap_oe = '0;
    done_cnt = 0;
    done_at = -1;
    @(posedge clk);
    #1 ncs = 1'b0;
    repeat (H) @(posedge clk);
    for (int i = 0; i < n; i++) begin
      #1 copi = (i < 16) ? f[15-i] : 1'b0;
      repeat (H - 1) @(posedge clk);
      @(negedge clk);
      if (i < 16) begin
        cap_c[15-i] = cipo;
        cap_oe[15-i] = cipo_oe;
      end
      @(posedge clk);
      #1 sclk = 1'b1;
      repeat (H) @(posedge clk);
      #1 sclk = 1'b0;
    end
    if (close) begin
      repeat (H) @(posedge clk);
      #1 ncs = 1'b1;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (txn_done) begin
          done_cnt++;
          if (done_at < 0) done_at = k;
        end
      end
    end
  endtask

  task automatic run(input logic [15:0] f, input int n);
    logic [7:0] rdv;
    logic [15:0] ec, eo;
    logic ed;
    int m;
    rdv = (f[14:8] <= 7'd4) ? model[f[10:8]] : 8'h00;
    ec = '0;
    eo = '0;
    m = (n < 16) ? n : 16;
    for (int i = 8; i < m; i++)
      if (RB && !f[15]) begin
        eo[15-i] = 1'b1;
        ec[15-i] = rdv[15-i];
      end
    ed = (n == 16) && (f[15] ? (f[14:8] <= 7'd4) : RB);
    if (ed && f[15]) model[f[10:8]] = f[7:0];
    send(f, n, 1'b1);
    chk("cipo_bits", 40'(cap_c), 40'(ec));
    chk("cipo_oe_bits", 40'(cap_oe), 40'(eo));
    chk("txn_count", 40'(done_cnt), 40'(ed));
    if (ed) chk("txn_latency", 40'(done_at), 40'(S + 1));
    chk("regs_model", dut_regs, mvec());
  endtask

  initial begin
    tbl[0]  = '{16'h80FF, 16, 1'b1, 40'h00_00_00_00_FF};
    tbl[1]  = '{16'h84C0, 16, 1'b1, 40'hC0_00_00_00_FF};
    tbl[2]  = '{16'h8533, 16, 1'b0, 40'hC0_00_00_00_FF};
    tbl[3]  = '{16'h8112, 12, 1'b0, 40'hC0_00_00_00_FF};
    tbl[4]  = '{16'h8112, 17, 1'b0, 40'hC0_00_00_00_FF};
    tbl[5]  = '{16'h0000, 16, RB,   40'hC0_00_00_00_FF};
    tbl[6]  = '{16'h8112, 16, 1'b1, 40'hC0_00_00_12_FF};
    tbl[7]  = '{16'h825A, 16, 1'b1, 40'hC0_00_5A_12_FF};
    tbl[8]  = '{16'h833C, 16, 1'b1, 40'hC0_3C_5A_12_FF};
    tbl[9]  = '{16'h0300, 16, RB,   40'hC0_3C_5A_12_FF};
    tbl[10] = '{16'h0112, 16, RB,   40'hC0_3C_5A_12_FF};
    tbl[11] = '{16'h0733, 16, RB,   40'hC0_3C_5A_12_FF};
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_regs", dut_regs, 40'h0);
    chk("reset_outs", 40'({txn_done, cipo, cipo_oe}), 40'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    for (int t = 0; t < 12; t++) begin
      run(tbl[t].frame, tbl[t].nbits);
      chk($sformatf("tbl%0d_regs", t), dut_regs, tbl[t].regs);
      chk($sformatf("tbl%0d_done", t), 40'(done_cnt), 40'(tbl[t].done));
    end
    send(16'h8299, 8, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midframe_reset_regs", dut_regs, 40'h0);
    chk("midframe_reset_outs", 40'({txn_done, cipo, cipo_oe}), 40'h0);
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    #1 ncs = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    run(16'h82A5, 16);
    chk("post_reset_pwm_lo", 40'(r2), 40'hA5);
    chk("post_reset_others", 40'({r4, r3, r1, r0}), 40'h0);
    for (int t = 0; t < 30; t++) begin
      logic [15:0] f;
      int r, n;
      f[15] = ($urandom_range(0, 3) != 0);
      f[14:8] = 7'($urandom_range(0, 6));
      f[7:0] = 8'($urandom);
      r = $urandom_range(0, 9);
      n = (r == 0) ? 12 : (r == 1) ? 17 : 16;
      run(f, n);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
